// File: rtl/cu_pkg.sv
// Shared types and encodings for the cu_seq sequencer: FSM states, instruction
// class/op codes, register-field positions and operand-use decode helpers.
package cu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic CLS_CTRL = 1'b0;
    localparam logic CLS_ALU  = 1'b1;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_MOV  = 3'd1;
    localparam logic [2:0] OP_LD   = 3'd2;
    localparam logic [2:0] OP_ST   = 3'd3;
    localparam logic [2:0] OP_LDI  = 3'd4;
    localparam logic [2:0] OP_JMP  = 3'd5;
    localparam logic [2:0] OP_JZ   = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam int RIDX_W = 4;
    localparam int D_LSB  = 4;
    localparam int S_LSB  = 0;

    // Only the register fields an op actually reads are range-checked.
    function automatic logic uses_d(input logic cls, input logic [2:0] op);
        return cls ? (op != ALU_NOT) : (op == OP_MOV);
    endfunction

    function automatic logic uses_s(input logic cls, input logic [2:0] op);
        return cls ? (op != ALU_SHL && op != ALU_SHR) : (op == OP_MOV);
    endfunction

endpackage

// File: rtl/cu_alu.sv
// Combinational DW-wide ALU for cu_seq class-1 ops; a = Rd, b = Rs.
module cu_alu
    import cu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~b;
            ALU_SHL: result = a << 1;
            ALU_SHR: result = a >> 1;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle fetch/decode/execute sequencer on one shared ready-handshaked
// memory port. Define CU_BRANCH_EN to enable JMP/JZ and the zero flag.
module cu_seq
    import cu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int NREGS = 12
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_en,
    output logic          mem_rwb,
    output logic [AW-1:0] mem_addr,
    output logic [AW+3:0] mem_wdata,
    input  logic [AW+3:0] mem_rdata,
    input  logic          mem_ready,
    output logic          halted,
    output logic          err,
    output logic [AW-1:0] pc
);

    localparam int IW = AW + 4;

    state_t          state, state_nx;
    logic [IW-1:0]   ir;
    logic [DW-1:0]   regs [NREGS];

    logic               cls;
    logic [2:0]         op;
    logic [RIDX_W-1:0]  fd, fs;
    logic [AW-1:0]      fa;
    logic               d_ok, s_ok, br_illegal, illegal, xfer;
    logic [DW-1:0]      rd_val, rs_val, alu_res;
    logic               alu_zero;

    assign cls  = ir[IW-1];
    assign op   = ir[IW-2:IW-4];
    assign fd   = ir[D_LSB +: RIDX_W];
    assign fs   = ir[S_LSB +: RIDX_W];
    assign fa   = ir[AW-1:0];

    assign d_ok   = 32'(fd) < NREGS;
    assign s_ok   = 32'(fs) < NREGS;
    assign rd_val = d_ok ? regs[fd] : '0;
    assign rs_val = s_ok ? regs[fs] : '0;

`ifdef CU_BRANCH_EN
    logic z;
    assign br_illegal = 1'b0;
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign br_illegal = (cls == CLS_CTRL) && (op == OP_JMP || op == OP_JZ);
`endif

    assign illegal = (uses_d(cls, op) && !d_ok) || (uses_s(cls, op) && !s_ok) || br_illegal;
    assign xfer    = mem_en && mem_ready;

    assign halted    = (state == HALT);
    assign mem_wdata = IW'(regs[0]);

    cu_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // Request is masked while rst is high so a pending transfer never completes.
    always_comb begin
        state_nx = state;
        mem_en   = !rst && (state == FETCH || state == MEM);
        mem_rwb  = 1'b1;
        mem_addr = pc;
        case (state)
            FETCH: if (xfer) state_nx = EXEC;
            EXEC: begin
                if (cls == CLS_CTRL && op == OP_HALT)                     state_nx = HALT;
                else if (cls == CLS_CTRL && (op == OP_LD || op == OP_ST)) state_nx = MEM;
                else                                                      state_nx = FETCH;
            end
            MEM: begin
                mem_addr = fa;
                mem_rwb  = (op != OP_ST);
                if (xfer) state_nx = FETCH;
            end
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            ir  <= '0;
            err <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef CU_BRANCH_EN
            z   <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: if (xfer) begin
                    ir <= mem_rdata;
                    pc <= pc + 1'b1;
                end
                EXEC: begin
                    if (illegal) begin
                        err <= 1'b1;
                    end else if (cls == CLS_ALU) begin
                        regs[0] <= alu_res;
`ifdef CU_BRANCH_EN
                        z <= alu_zero;
`endif
                    end else begin
                        case (op)
                            OP_MOV: regs[fd] <= rs_val;
                            OP_LDI: begin
                                regs[0] <= DW'(fa);
`ifdef CU_BRANCH_EN
                                z <= (DW'(fa) == '0);
`endif
                            end
`ifdef CU_BRANCH_EN
                            OP_JMP: pc <= fa;
                            OP_JZ:  if (z) pc <= fa;
`endif
                            default: ;
                        endcase
                    end
                end
                MEM: if (xfer && op == OP_LD) begin
                    regs[0] <= DW'(mem_rdata);
`ifdef CU_BRANCH_EN
                    z <= (DW'(mem_rdata) == '0);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_seq.sv
// Scoreboard bench for cu_seq: a memory model with programmable wait states
// checks every completed bus transfer against an expected-transaction queue.
module tb_cu_seq;

    logic        clk, rst;
    logic        mem_en, mem_rwb, mem_ready;
    logic [7:0]  mem_addr, pc;
    logic [11:0] mem_wdata, mem_rdata;
    logic        halted, err;

    cu_seq #(.DW(8), .AW(8), .NREGS(12)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_rwb(mem_rwb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .halted(halted), .err(err), .pc(pc)
    );

    typedef struct {
        logic        rwb;
        logic [7:0]  addr;
        logic [11:0] wdata;
        int          len;
    } txn_t;

    txn_t        sb[$];
    logic [11:0] mem [256];
    int          n_chk = 0, n_fail = 0;
    int          ready_delay = 0;
    int          pa = 0;
    int          req_len = 0;
    logic        held = 0;
    logic [7:0]  h_addr;
    logic        h_rwb;
    logic [11:0] h_wdata;

    assign mem_rdata = mem[mem_addr];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rwb, input logic [7:0] a, input logic [11:0] d);
        txn_t t;
        t.rwb = rwb; t.addr = a; t.wdata = d; t.len = ready_delay + 1;
        sb.push_back(t);
    endtask

    task automatic exp_fetch(input logic [7:0] a); push(1'b1, a, 12'h0); endtask
    task automatic exp_rd(input logic [7:0] a);    push(1'b1, a, 12'h0); endtask
    task automatic exp_wr(input logic [7:0] a, input logic [11:0] d); push(1'b0, a, d); endtask

    task automatic put(input logic [11:0] w);
        mem[pa[7:0]] = w;
        exp_fetch(pa[7:0]);
        pa++;
    endtask

    task automatic fill(input logic [11:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
        pa = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rwb", mem_rwb, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        sb.delete();
    endtask

    task automatic run_until_halt(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!halted && n < limit);
        chk("halt_reached", halted, 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    // Memory model and transfer monitor; ready rises after ready_delay wait cycles.
    initial begin
        mem_ready = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                mem_ready = (req_len >= ready_delay);
                if (held) begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_rwb", mem_rwb, h_rwb);
                    chk("hold_wdata", mem_wdata, h_wdata);
                end
                if (mem_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected", sb.size(), 1);
                    end else begin
                        txn_t e;
                        e = sb.pop_front();
                        chk("txn_rwb", mem_rwb, e.rwb);
                        chk("txn_addr", mem_addr, e.addr);
                        chk("txn_len", req_len + 1, e.len);
                        if (!e.rwb) chk("txn_wdata", mem_wdata, e.wdata);
                    end
                    if (!mem_rwb) mem[mem_addr] = mem_wdata;
                    held = 0; req_len = 0;
                end else begin
                    held = 1; h_addr = mem_addr; h_rwb = mem_rwb; h_wdata = mem_wdata;
                    req_len++;
                end
            end else begin
                mem_ready = 0; held = 0; req_len = 0;
            end
        end
    end

    initial begin
        int n;
        logic [7:0] exp_v [7];
        rst = 1;

        // Basic program: 5+3 through MOV and ADD, 10 cycles to halt.
        ready_delay = 0;
        do_reset();
        fill(12'h000);
        put(12'h405); put(12'h110); put(12'h403); put(12'h810); put(12'h000);
        rst = 0;
        run_until_halt(100, n);
        chk("prog_cycles", n, 10);
        chk("prog_r0", dut.regs[0], 8'h08);
        chk("prog_r1", dut.regs[1], 8'h05);
        chk("prog_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_idle_en", mem_en, 0);
        end

        // Store with 3 wait states, clear R0, load it back.
        ready_delay = 3;
        do_reset();
        fill(12'h000);
        put(12'h45A); put(12'h340); exp_wr(8'h40, 12'h05A);
        put(12'h400); put(12'h240); exp_rd(8'h40); put(12'h000);
        rst = 0;
        run_until_halt(200, n);
        chk("ldst_r0", dut.regs[0], 8'h5A);
        chk("ldst_mem", mem[8'h40], 12'h05A);

        // SUB of equal registers then JZ 0x10.
        ready_delay = 0;
        do_reset();
        fill(12'h000);
        put(12'h407); put(12'h120); put(12'h920); put(12'h610);
`ifdef CU_BRANCH_EN
        exp_fetch(8'h10);
`else
        exp_fetch(8'h04);
`endif
        rst = 0;
        run_until_halt(100, n);
        chk("jz_r0", dut.regs[0], 8'h00);
`ifdef CU_BRANCH_EN
        chk("jz_z", dut.z, 1);
        chk("jz_err", err, 0);
`else
        chk("jz_err", err, 1);
`endif

        // MOV to R13 with 12 registers: ignored, err set, execution continues.
        ready_delay = 1;
        do_reset();
        fill(12'h000);
        put(12'h409); put(12'h110); put(12'h1D1); put(12'h404); put(12'h000);
        rst = 0;
        run_until_halt(200, n);
        chk("badreg_err", err, 1);
        chk("badreg_r0", dut.regs[0], 8'h04);
        chk("badreg_r1", dut.regs[1], 8'h09);
        for (int i = 2; i < 12; i++) chk("badreg_rx", dut.regs[i], 8'h00);

        // ALU ops observed through stores: R3=0x0C, R4=0x0A.
        ready_delay = 1;
        exp_v[0] = 8'h0E; exp_v[1] = 8'h08; exp_v[2] = 8'h06; exp_v[3] = 8'hF5;
        exp_v[4] = 8'h18; exp_v[5] = 8'h06; exp_v[6] = 8'hFE;
        do_reset();
        fill(12'h000);
        put(12'h40C); put(12'h130); put(12'h40A); put(12'h140);
        put(12'hB34); put(12'h350); exp_wr(8'h50, {4'h0, exp_v[0]});
        put(12'hA34); put(12'h351); exp_wr(8'h51, {4'h0, exp_v[1]});
        put(12'hC34); put(12'h352); exp_wr(8'h52, {4'h0, exp_v[2]});
        put(12'hD04); put(12'h353); exp_wr(8'h53, {4'h0, exp_v[3]});
        put(12'hE30); put(12'h354); exp_wr(8'h54, {4'h0, exp_v[4]});
        put(12'hF30); put(12'h355); exp_wr(8'h55, {4'h0, exp_v[5]});
        put(12'h943); put(12'h356); exp_wr(8'h56, {4'h0, exp_v[6]});
        put(12'h000);
        rst = 0;
        run_until_halt(500, n);
        chk("alu_err", err, 0);

        // pc wrap: NOPs to 0xFF; the store turns address 0 into HALT for the second pass.
        ready_delay = 0;
        do_reset();
        fill(12'h700);
        put(12'h400); put(12'h300); exp_wr(8'h00, 12'h000);
        for (int i = 2; i < 256; i++) put(12'h700);
        exp_fetch(8'h00);
        rst = 0;
        run_until_halt(2000, n);
        chk("wrap_pc", pc, 8'h01);
        chk("wrap_err", err, 0);

        // Reset during a LD wait: request dropped, load discarded, fetch restarts at 0.
        ready_delay = 5;
        do_reset();
        fill(12'h000);
        mem[8'h40] = 12'h077;
        put(12'h433); put(12'h240);
        rst = 0;
        n = 0;
        while (!(mem_en && mem_rwb && mem_addr == 8'h40) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ldwait_seen", mem_addr, 8'h40);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        chk("ldrst_en", mem_en, 0);
        chk("ldrst_pc", pc, 0);
        chk("ldrst_r0", dut.regs[0], 8'h00);
        chk("ldrst_sb", sb.size(), 0);
        ready_delay = 0;
        sb.delete();
        pa = 0;
        put(12'h433); put(12'h240); exp_rd(8'h40); put(12'h000);
        rst = 0;
        run_until_halt(100, n);
        chk("ldrst_reload", dut.regs[0], 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
